// File: rtl/mc_defs.sv
// Shared encodings for the MIPS-lite multi-cycle controller: opcodes, functs, states,
// writeback/ALU/next-PC select codes and the one-hot instruction class.
package mc_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC     = 4'd2,
      S_ALU_WB   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8
   } state_e;

   localparam logic [1:0] DST_RT  = 2'b00;
   localparam logic [1:0] DST_RD  = 2'b01;
   localparam logic [1:0] DST_RA  = 2'b10;

   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_MEM  = 2'b01;
   localparam logic [1:0] WD_PC   = 2'b10;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_LUI = 2'b11;

   typedef struct packed {
      logic rtype_alu;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic jr;
      logic illegal;
   } iclass_t;

   // ALU operation for the EXEC/ALU_WB classes; R-type splits on funct.
   function automatic logic [1:0] alu_op_of(input iclass_t cls, input logic [5:0] funct);
      logic [1:0] op;
      op = ALU_ADD;
      if (cls.ori)
         op = ALU_OR;
      else if (cls.lui)
         op = ALU_LUI;
      else if (cls.rtype_alu && funct == FN_SUBU)
         op = ALU_SUB;
      return op;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
module mc_decode
   import mc_defs::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
               FN_JR:            cls.jr        = 1'b1;
               default:          cls.illegal   = 1'b1;
            endcase
         end
         OP_ORI:  cls.ori     = 1'b1;
         OP_LUI:  cls.lui     = 1'b1;
         OP_LW:   cls.lw      = 1'b1;
         OP_SW:   cls.sw      = 1'b1;
         OP_BEQ:  cls.beq     = 1'b1;
         OP_J:    cls.j       = 1'b1;
         OP_JAL:  cls.jal     = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with Moore-style
// per-state outputs qualified by instruction class, plus a retired-instruction counter.
module mc_ctrl
   import mc_defs::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic             mem_we,
   output logic [1:0]       reg_dst_sel,
   output logic [1:0]       wd_sel,
   output logic             alu_src_sel,
   output logic             ext_op,
   output logic [1:0]       alu_op,
   output logic [1:0]       npc_sel,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   iclass_t          cls;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;
   logic             pc_we_c, ir_we_c, reg_we_c, mem_we_c, alu_src_c, ext_op_c, illegal_c;
   logic [1:0]       reg_dst_c, wd_sel_c, alu_op_c, npc_sel_c;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .cls    (cls)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retire    = 1'b0;
      pc_we_c   = 1'b0;
      ir_we_c   = 1'b0;
      reg_we_c  = 1'b0;
      mem_we_c  = 1'b0;
      alu_src_c = 1'b0;
      ext_op_c  = 1'b0;
      illegal_c = 1'b0;
      reg_dst_c = DST_RT;
      wd_sel_c  = WD_ALU;
      alu_op_c  = ALU_ADD;
      npc_sel_c = NPC_PC4;
      case (state_q)
         S_FETCH: begin
            ir_we_c = 1'b1;
            pc_we_c = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (cls.j || cls.jal || cls.jr) begin
               pc_we_c   = 1'b1;
               npc_sel_c = cls.jr ? NPC_JR : NPC_J;
               retire    = 1'b1;
               state_d   = S_FETCH;
               // jal links through the writeback mux on the same edge the PC jumps
               if (cls.jal) begin
                  reg_we_c  = 1'b1;
                  reg_dst_c = DST_RA;
                  wd_sel_c  = WD_PC;
               end
            end else if (cls.beq) begin
               state_d = S_BRANCH;
            end else if (cls.rtype_alu || cls.ori || cls.lui) begin
               state_d = S_EXEC;
            end else if (cls.lw || cls.sw) begin
               state_d = S_MEM_ADDR;
            end else begin
               illegal_c = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_EXEC, S_ALU_WB: begin
            alu_op_c  = alu_op_of(cls, funct);
            alu_src_c = !cls.rtype_alu;
            if (state_q == S_EXEC) begin
               state_d = S_ALU_WB;
            end else begin
               reg_we_c  = 1'b1;
               reg_dst_c = cls.rtype_alu ? DST_RD : DST_RT;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            alu_src_c = 1'b1;
            ext_op_c  = 1'b1;
            state_d   = cls.lw ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_WR: begin
            alu_src_c = 1'b1;
            ext_op_c  = 1'b1;
            mem_we_c  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_RD: begin
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_we_c = 1'b1;
            wd_sel_c = WD_MEM;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alu_op_c = ALU_SUB;
            ext_op_c = 1'b1;
            if (zero) begin
               pc_we_c   = 1'b1;
               npc_sel_c = NPC_BR;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (retire)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // While reset is low the FETCH state would otherwise drive ir_we/pc_we.
   assign pc_we       = reset & pc_we_c;
   assign ir_we       = reset & ir_we_c;
   assign reg_we      = reset & reg_we_c;
   assign mem_we      = reset & mem_we_c;
   assign alu_src_sel = reset & alu_src_c;
   assign ext_op      = reset & ext_op_c;
   assign illegal     = reset & illegal_c;
   assign reg_dst_sel = reset ? reg_dst_c : 2'b00;
   assign wd_sel      = reset ? wd_sel_c  : 2'b00;
   assign alu_op      = reset ? alu_op_c  : 2'b00;
   assign npc_sel     = reset ? npc_sel_c : 2'b00;
   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares every output each cycle.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  opcode = 6'b100011;
   logic [5:0]  funct = 6'b000000;
   logic        zero = 1'b0;
   logic        pc_we, ir_we, reg_we, mem_we, alu_src_sel, ext_op, illegal;
   logic [1:0]  reg_dst_sel, wd_sel, alu_op, npc_sel;
   logic [3:0]  state;
   logic [31:0] instr_count;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .pc_we       (pc_we),
      .ir_we       (ir_we),
      .reg_we      (reg_we),
      .mem_we      (mem_we),
      .reg_dst_sel (reg_dst_sel),
      .wd_sel      (wd_sel),
      .alu_src_sel (alu_src_sel),
      .ext_op      (ext_op),
      .alu_op      (alu_op),
      .npc_sel     (npc_sel),
      .illegal     (illegal),
      .state       (state),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  st;
      logic [14:0] v;
      logic [31:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          passes = 0;
   logic [31:0] exp_cnt = 0;

   // {pc_we, ir_we, reg_we, mem_we, reg_dst[2], wd[2], alu_src, ext, alu_op[2], npc[2], illegal}
   function automatic logic [14:0] vec(input logic pc, input logic ir, input logic rw,
                                       input logic mw, input logic [1:0] dst,
                                       input logic [1:0] wd, input logic src,
                                       input logic ext, input logic [1:0] aop,
                                       input logic [1:0] npc, input logic ill);
      return {pc, ir, rw, mw, dst, wd, src, ext, aop, npc, ill};
   endfunction

   function automatic logic [14:0] got_vec();
      return {pc_we, ir_we, reg_we, mem_we, reg_dst_sel, wd_sel, alu_src_sel, ext_op,
              alu_op, npc_sel, illegal};
   endfunction

   task automatic push(input string n, input logic [3:0] st, input logic [14:0] v);
      exp_t e;
      e.name = n;
      e.st   = st;
      e.v    = v;
      e.cnt  = exp_cnt;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (state !== e.st || got_vec() !== e.v || instr_count !== e.cnt)
            $display("FAIL %s: got state=%0d outs=%b cnt=%0d, want state=%0d outs=%b cnt=%0d",
                     e.name, state, got_vec(), instr_count, e.st, e.v, e.cnt);
         else begin
            passes++;
            $display("ok   %s: state=%0d outs=%b cnt=%0d", e.name, state, got_vec(), instr_count);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   logic [14:0] F, Z;

   initial begin
      F = vec(1,1,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0);
      Z = '0;
      @(posedge clk);
      #1;
      // reset held with lw on the opcode bus
      issue(6'b100011, 6'b000000, 1'b0);
      push("rst0", 0, Z); push("rst1", 0, Z); push("rst2", 0, Z);
      step(3);
      reset = 1'b1;

      push("lw F", 0, F);
      push("lw D", 1, Z);
      push("lw MA", 4, vec(0,0,0,0,2'b00,2'b00,1,1,2'b00,2'b00,0));
      push("lw MR", 5, Z);
      push("lw MWB", 6, vec(0,0,1,0,2'b00,2'b01,0,0,2'b00,2'b00,0));
      step(5); exp_cnt++;

      issue(6'b000000, 6'b100001, 1'b0);
      push("addu F", 0, F);
      push("addu D", 1, Z);
      push("addu EX", 2, Z);
      push("addu WB", 3, vec(0,0,1,0,2'b01,2'b00,0,0,2'b00,2'b00,0));
      step(4); exp_cnt++;

      issue(6'b000000, 6'b100011, 1'b0);
      push("subu F", 0, F);
      push("subu D", 1, Z);
      push("subu EX", 2, vec(0,0,0,0,2'b00,2'b00,0,0,2'b01,2'b00,0));
      push("subu WB", 3, vec(0,0,1,0,2'b01,2'b00,0,0,2'b01,2'b00,0));
      step(4); exp_cnt++;

      issue(6'b101011, 6'b000000, 1'b0);
      push("sw F", 0, F);
      push("sw D", 1, Z);
      push("sw MA", 4, vec(0,0,0,0,2'b00,2'b00,1,1,2'b00,2'b00,0));
      push("sw MW", 7, vec(0,0,0,1,2'b00,2'b00,1,1,2'b00,2'b00,0));
      step(4); exp_cnt++;

      issue(6'b001101, 6'b000000, 1'b0);
      push("ori F", 0, F);
      push("ori D", 1, Z);
      push("ori EX", 2, vec(0,0,0,0,2'b00,2'b00,1,0,2'b10,2'b00,0));
      push("ori WB", 3, vec(0,0,1,0,2'b00,2'b00,1,0,2'b10,2'b00,0));
      step(4); exp_cnt++;

      issue(6'b001111, 6'b000000, 1'b0);
      push("lui F", 0, F);
      push("lui D", 1, Z);
      push("lui EX", 2, vec(0,0,0,0,2'b00,2'b00,1,0,2'b11,2'b00,0));
      push("lui WB", 3, vec(0,0,1,0,2'b00,2'b00,1,0,2'b11,2'b00,0));
      step(4); exp_cnt++;

      issue(6'b000100, 6'b000000, 1'b1);
      push("beq1 F", 0, F);
      push("beq1 D", 1, Z);
      push("beq1 BR", 8, vec(1,0,0,0,2'b00,2'b00,0,1,2'b01,2'b01,0));
      step(3); exp_cnt++;

      issue(6'b000100, 6'b000000, 1'b0);
      push("beq0 F", 0, F);
      push("beq0 D", 1, Z);
      push("beq0 BR", 8, vec(0,0,0,0,2'b00,2'b00,0,1,2'b01,2'b00,0));
      step(3); exp_cnt++;

      issue(6'b000010, 6'b000000, 1'b0);
      push("j F", 0, F);
      push("j D", 1, vec(1,0,0,0,2'b00,2'b00,0,0,2'b00,2'b10,0));
      step(2); exp_cnt++;

      issue(6'b000011, 6'b000000, 1'b0);
      push("jal F", 0, F);
      push("jal D", 1, vec(1,0,1,0,2'b10,2'b10,0,0,2'b00,2'b10,0));
      step(2); exp_cnt++;

      issue(6'b000000, 6'b001000, 1'b0);
      push("jr F", 0, F);
      push("jr D", 1, vec(1,0,0,0,2'b00,2'b00,0,0,2'b00,2'b11,0));
      step(2); exp_cnt++;

      // illegal instructions retire without counting
      issue(6'b111111, 6'b000000, 1'b0);
      push("ill F", 0, F);
      push("ill D", 1, vec(0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,1));
      step(2);

      issue(6'b000000, 6'b100000, 1'b0);
      push("badfn F", 0, F);
      push("badfn D", 1, vec(0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,1));
      step(2);

      // lw interrupted by reset while in MEM_RD
      issue(6'b100011, 6'b000000, 1'b0);
      push("lwr F", 0, F);
      push("lwr D", 1, Z);
      push("lwr MA", 4, vec(0,0,0,0,2'b00,2'b00,1,1,2'b00,2'b00,0));
      push("lwr MR", 5, Z);
      step(3);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || got_vec() !== 15'd0 || instr_count !== 32'd0)
         $display("FAIL async_rst: got state=%0d outs=%b cnt=%0d, want state=0 outs=0 cnt=0",
                  state, got_vec(), instr_count);
      else begin
         passes++;
         $display("ok   async_rst: state=%0d outs=%b cnt=%0d", state, got_vec(), instr_count);
      end
      exp_cnt = 0;
      @(posedge clk);
      #1;
      push("rstB0", 0, Z); push("rstB1", 0, Z);
      step(2);
      reset = 1'b1;

      issue(6'b000010, 6'b000000, 1'b0);
      push("j2 F", 0, F);
      push("j2 D", 1, vec(1,0,0,0,2'b00,2'b00,0,0,2'b00,2'b10,0));
      step(2); exp_cnt++;

      issue(6'b000000, 6'b100001, 1'b0);
      push("addu2 F", 0, F);
      step(1);

      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS-lite datapath. It sits directly upstream of the writeback muxes, driving the register-destination select (rt/rd/ra), the write-data select (alu/mem/pc), and every write enable. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states from the opcode and funct fields of the instruction register.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], stable from the cycle after FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag, valid in BRANCH
pc_we  out  1  PC write enable
ir_we  out  1  IR write enable
reg_we  out  1  GRF write enable
mem_we  out  1  DM write enable
reg_dst_sel  out  2  00 rt, 01 rd, 10 ra (31)
wd_sel  out  2  00 alu, 01 mem, 10 pc (PC already +4)
alu_src_sel  out  1  0 rt data, 1 extended imm
ext_op  out  1  0 zero-extend, 1 sign-extend
alu_op  out  2  00 add, 01 sub, 10 or, 11 lui (imm<<16)
npc_sel  out  2  00 pc+4, 01 branch, 10 j, 11 jr
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state encoding, for debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Decoded set: R-type (opcode 000000) with funct addu 100001, subu 100011, jr 001000; ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011. Anything else is illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, ALU_WB 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8.
- The state register is the only sequential element besides instr_count. Outputs are combinational from the state, opcode and funct (Moore per state, class-qualified).
- Reset low: state=FETCH, instr_count=0. All outputs are forced to 0 while reset is low, including ir_we and pc_we. The first FETCH takes effect on the first rising edge after release.
- Reset mid-instruction: state is abandoned immediately. No partial write-enable is asserted after reset goes low.
- FETCH: ir_we=1, pc_we=1, npc_sel=00. Next state DECODE.
- DECODE:
  - j: pc_we, npc_sel=10, then FETCH.
  - jal: pc_we, npc_sel=10, reg_we, reg_dst_sel=10, wd_sel=10, then FETCH. GRF and PC are written on the same edge; the GRF captures the pre-jump PC value (PC+4).
  - jr: pc_we, npc_sel=11, then FETCH.
  - beq: BRANCH.
  - addu/subu/ori/lui: EXEC.
  - lw/sw: MEM_ADDR.
  - illegal: illegal=1, no enables, then FETCH.
- EXEC: alu_op from class; alu_src_sel=1 and ext_op=0 for ori/lui; alu_src_sel=0 for R-type. Next ALU_WB.
- ALU_WB: reg_we=1, wd_sel=00, reg_dst_sel=01 for R-type, 00 for ori/lui. ALU controls are held as in EXEC. Next FETCH.
- MEM_ADDR: alu_op=00, alu_src_sel=1, ext_op=1. Next MEM_RD for lw, MEM_WR for sw.
- MEM_WR: mem_we=1, address controls held. Next FETCH.
- MEM_RD: next MEM_WB. MEM_WB: reg_we=1, wd_sel=01, reg_dst_sel=00. Next FETCH.
- BRANCH: alu_op=01, alu_src_sel=0, ext_op=1. If zero=1: pc_we=1, npc_sel=01. Next FETCH.
- CPI: j/jal/jr 2; beq 3; sw 4; R-type/ori/lui 4; lw 5; illegal 2.
- instr_count increments on each transition into FETCH from a non-illegal instruction, and wraps modulo 2^CNT_W. An illegal instruction does not count.
- Unreachable state codes (9-15) return to FETCH on the next edge with all outputs 0.
- Outputs not listed for a state are 0.

Decomposition:
- Shared package mc_defs holds:
  - opcode and funct constants;
  - state encodings;
  - the 2-bit select encodings for reg_dst_sel (rt/rd/ra), wd_sel (alu/mem/pc), npc_sel and alu_op, so the muxes and the controller use one definition.
- One natural sub-module, mc_decode: purely combinational. It maps opcode/funct to a one-hot instruction class (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, illegal). The FSM in mc_ctrl consumes that class.

Test Plan:
- Reset: hold reset=0 for 3 clocks with opcode=lw. Required: all enables 0, state=0, instr_count=0. Release: the first edge gives state=1.
- addu (opcode 0, funct 100001): states 0,1,2,3,0. ALU_WB has reg_we=1, reg_dst_sel=01, wd_sel=00, alu_op=00. instr_count increments by 1.
- lw (100011): 5 cycles. MEM_ADDR has ext_op=1, alu_src_sel=1. MEM_WB has reg_we=1, wd_sel=01, reg_dst_sel=00. Same sequence with sw (101011): 4 cycles, mem_we=1 only in MEM_WR, reg_we never set.
- beq: run once with zero=1 (pc_we=1, npc_sel=01 in BRANCH) and once with zero=0 (pc_we=0). Both take 3 cycles.
- jal (000011): DECODE has pc_we=1, npc_sel=10, reg_we=1, reg_dst_sel=10, wd_sel=10. jr: DECODE has npc_sel=11.
- Illegal opcode 111111: illegal pulses for exactly 1 cycle in DECODE, then FETCH, with instr_count unchanged. Repeat with reset pulled low in MEM_RD of a lw: no reg_we, and state returns to 0 asynchronously.
